// File: rtl/dbus_master.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_master
//  Description : Single-outstanding load/store initiator for the data bus.
//                Builds store lanes, aligns/extends load data, flags
//                misaligned or illegal-size requests without a bus access.
//  Revision    : 1.0 - initial release
// ============================================================================
module dbus_master #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  rd_en,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-3:0] addr,
    output logic [31:0]           wr_data,
    output logic [3:0]            wr_strobe,
    input  logic [31:0]           rd_data
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUS  = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_we;
    logic [1:0]            r_size;
    logic [1:0]            r_off;
    logic                  r_unsigned;
    logic                  r_rd_en;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-3:0] r_addr;
    logic [31:0]           r_wr_data;
    logic [3:0]            r_wr_strobe;
    logic                  r_resp_valid;
    logic [31:0]           r_resp_rdata;
    logic                  r_resp_err;

    logic [1:0]            w_off;
    logic                  w_legal;
    logic [31:0]           w_lane_data;
    logic [3:0]            w_lane_strobe;
    logic [31:0]           w_shifted;
    logic [31:0]           w_load;

    assign w_off = req_addr[1:0];

    always_comb begin
        w_legal       = 1'b0;
        w_lane_data   = req_wdata;
        w_lane_strobe = 4'b1111;
        case (req_size)
            2'b00: begin
                w_legal       = 1'b1;
                w_lane_data   = {4{req_wdata[7:0]}};
                w_lane_strobe = 4'b0001 << w_off;
            end
            2'b01: begin
                w_legal       = ~w_off[0];
                w_lane_data   = {2{req_wdata[15:0]}};
                w_lane_strobe = 4'b0011 << w_off;
            end
            2'b10: w_legal = (w_off == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    // Load data arrives combinationally during BUS; align using the latched offset.
    assign w_shifted = rd_data >> {r_off, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (r_size)
            2'b00:   w_load = {{24{~r_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_load = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (req_valid) w_state_nxt = w_legal ? c_ST_BUS : c_ST_RESP;
            c_ST_BUS:  w_state_nxt = c_ST_RESP;
            c_ST_RESP: if (resp_ready) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= 2'b00;
            r_unsigned   <= 1'b0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_wr_strobe  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_off      <= w_off;
                        r_unsigned <= req_unsigned;
                        if (w_legal) begin
                            r_rd_en     <= ~req_we;
                            r_wr_en     <= req_we;
                            r_addr      <= req_addr[ADDR_WIDTH-1:2];
                            r_wr_data   <= req_we ? w_lane_data : 32'd0;
                            r_wr_strobe <= req_we ? w_lane_strobe : 4'd0;
                        end else begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'd0;
                        end
                    end
                end
                c_ST_BUS: begin
                    r_rd_en      <= 1'b0;
                    r_wr_en      <= 1'b0;
                    r_addr       <= '0;
                    r_wr_data    <= '0;
                    r_wr_strobe  <= '0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= r_we ? 32'd0 : w_load;
                end
                c_ST_RESP: if (resp_ready) r_resp_valid <= 1'b0;
                default: r_resp_valid <= 1'b0;
            endcase
        end
    end

    assign req_ready  = (r_state == c_ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign rd_en      = r_rd_en;
    assign wr_en      = r_wr_en;
    assign addr       = r_addr;
    assign wr_data    = r_wr_data;
    assign wr_strobe  = r_wr_strobe;

endmodule
`default_nettype wire

// File: tb/tb_dbus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbus_master
//  Description : Self-checking bench for dbus_master: directed cases plus
//                randomized traffic against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_master;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_we, req_unsigned, resp_ready;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic [31:0]   req_wdata, rd_data;
    wire           req_ready, resp_valid, resp_err, rd_en, wr_en;
    wire  [31:0]   resp_rdata, wr_data;
    wire  [AW-3:0] addr;
    wire  [3:0]    wr_strobe;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic          rd_fixed_en;
    logic [31:0]   rd_fixed;

    dbus_master #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .rd_en(rd_en), .wr_en(wr_en),
        .addr(addr), .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic bit legal(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 1'b1;
            2'd1:    return (off % 2) == 0;
            2'd2:    return off == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] lanes(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return wd[7:0] * 32'h0101_0101;
        if (sz == 2'd1) return wd[15:0] * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] strobes(input logic [1:0] sz, input logic [1:0] off);
        int o = off;
        if (sz == 2'd0) return 4'(1 << o);
        if (sz == 2'd1) return 4'(3 << o);
        return 4'hF;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] d, input logic [1:0] sz,
                                             input logic [1:0] off, input logic uns);
        logic [7:0] b [4];
        int o = off;
        int v;
        for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
        if (sz == 2'd0) begin
            v = b[o];
            if (!uns && v >= 128) v = v - 256;
            return 32'(v);
        end
        if (sz == 2'd1) begin
            v = b[(o + 1) % 4] * 256 + b[o];
            if (!uns && v >= 32768) v = v - 65536;
            return 32'(v);
        end
        return d;
    endfunction

    // ---------------- transaction-level model ----------------
    logic          m_ready, m_bus, m_rd, m_wr, m_rv, m_err;
    logic [AW-3:0] m_addr;
    logic [31:0]   m_wdata, m_rdata;
    logic [3:0]    m_strb;
    logic          p_we, p_uns;
    logic [1:0]    p_size, p_off;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b1; m_bus <= 1'b0; m_rd <= 1'b0; m_wr <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_strb <= '0;
            m_rv <= 1'b0; m_rdata <= '0; m_err <= 1'b0;
        end else if (m_bus) begin
            m_bus <= 1'b0; m_rd <= 1'b0; m_wr <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_strb <= '0;
            m_rv <= 1'b1; m_err <= 1'b0;
            m_rdata <= p_we ? 32'd0 : load_val(rd_data, p_size, p_off, p_uns);
        end else if (m_rv) begin
            if (resp_ready) begin
                m_rv <= 1'b0; m_ready <= 1'b1;
            end
        end else if (req_valid) begin
            m_ready <= 1'b0;
            p_we <= req_we; p_uns <= req_unsigned; p_size <= req_size; p_off <= req_addr[1:0];
            if (legal(req_size, req_addr[1:0])) begin
                m_bus   <= 1'b1;
                m_rd    <= !req_we;
                m_wr    <= req_we;
                m_addr  <= req_addr[AW-1:2];
                m_wdata <= req_we ? lanes(req_size, req_wdata) : 32'd0;
                m_strb  <= req_we ? strobes(req_size, req_addr[1:0]) : 4'd0;
            end else begin
                m_rv <= 1'b1; m_err <= 1'b1; m_rdata <= 32'd0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready", req_ready, m_ready);
            chk("rd_en", rd_en, m_rd);
            chk("wr_en", wr_en, m_wr);
            chk("addr", addr, m_addr);
            chk("wr_strobe", wr_strobe, m_strb);
            if (!(m_bus && m_rd)) chk("wr_data", wr_data, m_wdata);
            chk("resp_valid", resp_valid, m_rv);
            if (m_rv) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_err", resp_err, m_err);
            end
        end
    end

    // Bus read data changes every cycle so a late or early capture shows up.
    initial begin
        rd_data = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            rd_data = rd_fixed_en ? rd_fixed : $urandom;
        end
    end

    // ---------------- directed transaction helper ----------------
    task automatic run_txn(input logic we, input logic [31:0] a, input logic [1:0] sz,
                           input logic uns, input logic [31:0] wd,
                           output int bus_k, output int resp_k, output logic [31:0] b_addr,
                           output logic [31:0] b_wdata, output logic [3:0] b_strb,
                           output logic [31:0] r_data, output logic r_err);
        bit acc = 0;
        @(posedge clk); #2;
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) acc = 1;
        end
        chk("accept_in_time", 32'(acc), 32'd1);
        @(posedge clk); #2;
        req_valid = 1'b0;
        bus_k = 0; resp_k = 0; b_addr = 0; b_wdata = 0; b_strb = 0; r_data = 0; r_err = 0;
        for (int k = 1; k <= 10 && resp_k == 0; k++) begin
            @(negedge clk);
            if ((rd_en || wr_en) && bus_k == 0) begin
                bus_k = k; b_addr = 32'(addr); b_wdata = wr_data; b_strb = wr_strobe;
            end
            if (resp_valid) begin
                resp_k = k; r_data = resp_rdata; r_err = resp_err;
            end
        end
        chk("resp_in_time", 32'(resp_k != 0), 32'd1);
    endtask

    int          bk, rk;
    logic [31:0] ba, bw, rdv, hold_v;
    logic [3:0]  bs;
    logic        re, hold_e;
    bit          seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b1;
        rd_fixed_en = 1'b1; rd_fixed = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1); chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0); chk("rst_resp_err", resp_err, 0);
        chk("rst_rd_en", rd_en, 0); chk("rst_wr_en", wr_en, 0); chk("rst_addr", addr, 0);
        chk("rst_wr_data", wr_data, 0); chk("rst_wr_strobe", wr_strobe, 0);

        // word load
        rd_fixed = 32'hDEADBEEF;
        run_txn(0, 32'h0000_1008, 2'd2, 0, 0, bk, rk, ba, bw, bs, rdv, re);
        chk("wl_bus_cycle", bk, 1); chk("wl_addr", ba, 32'h402);
        chk("wl_resp_cycle", rk, 2); chk("wl_rdata", rdv, 32'hDEADBEEF); chk("wl_err", re, 0);

        // byte/half loads with sign and zero extension
        rd_fixed = 32'h80FF_0000;
        run_txn(0, 32'h0000_2003, 2'd0, 0, 0, bk, rk, ba, bw, bs, rdv, re);
        chk("lb_signed", rdv, 32'hFFFF_FF80);
        run_txn(0, 32'h0000_2003, 2'd0, 1, 0, bk, rk, ba, bw, bs, rdv, re);
        chk("lb_unsigned", rdv, 32'h0000_0080);
        run_txn(0, 32'h0000_2002, 2'd1, 0, 0, bk, rk, ba, bw, bs, rdv, re);
        chk("lh_signed", rdv, 32'hFFFF_80FF);

        // stores
        run_txn(1, 32'h0000_3001, 2'd0, 0, 32'h1234_56AB, bk, rk, ba, bw, bs, rdv, re);
        chk("sb_strobe", bs, 4'b0010); chk("sb_data", bw, 32'hABAB_ABAB);
        chk("sb_rdata", rdv, 0); chk("sb_resp_cycle", rk, 2);
        run_txn(1, 32'h0000_3002, 2'd1, 0, 32'h0000_BEEF, bk, rk, ba, bw, bs, rdv, re);
        chk("sh_strobe", bs, 4'b1100); chk("sh_data", bw, 32'hBEEF_BEEF);
        run_txn(1, 32'h0000_3004, 2'd2, 0, 32'hCAFE_F00D, bk, rk, ba, bw, bs, rdv, re);
        chk("sw_strobe", bs, 4'b1111); chk("sw_data", bw, 32'hCAFE_F00D);

        // errors: no bus cycle, response one cycle after handshake
        run_txn(0, 32'h0000_4002, 2'd2, 0, 0, bk, rk, ba, bw, bs, rdv, re);
        chk("mw_no_bus", bk, 0); chk("mw_resp_cycle", rk, 1); chk("mw_err", re, 1); chk("mw_rdata", rdv, 0);
        run_txn(1, 32'h0000_4003, 2'd1, 0, 32'hFFFF_FFFF, bk, rk, ba, bw, bs, rdv, re);
        chk("mh_no_bus", bk, 0); chk("mh_err", re, 1); chk("mh_rdata", rdv, 0);
        run_txn(0, 32'h0000_4000, 2'd3, 0, 0, bk, rk, ba, bw, bs, rdv, re);
        chk("sz3_no_bus", bk, 0); chk("sz3_resp_cycle", rk, 1); chk("sz3_err", re, 1);

        // backpressure with a competing request
        @(posedge clk); #2;
        resp_ready = 1'b0; rd_fixed = 32'h1122_3344;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_size = 2'd2; req_unsigned = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (req_ready) seen = 1;
        end
        @(posedge clk); #2;
        req_addr = 32'h21; req_size = 2'd0; req_unsigned = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        chk("bp_resp_seen", 32'(seen), 1);
        hold_v = resp_rdata; hold_e = resp_err;
        chk("bp_rdata", hold_v, 32'h1122_3344);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", resp_valid, 1); chk("bp_hold_rdata", resp_rdata, hold_v);
            chk("bp_hold_err", resp_err, hold_e); chk("bp_hold_ready", req_ready, 0);
        end
        @(posedge clk); #2 resp_ready = 1'b1;
        @(negedge clk); chk("bp_not_yet_ready", req_ready, 0);
        @(negedge clk); chk("bp_ready_after", req_ready, 1);
        @(posedge clk); #2 req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        chk("bp_second_seen", 32'(seen), 1);
        chk("bp_second_rdata", resp_rdata, 32'h0000_0033);

        // asynchronous reset in the middle of a bus cycle
        @(posedge clk); #2;
        rd_fixed = 32'h5555_AAAA;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 2'd2; req_wdata = 32'h0BAD_F00D;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (req_ready) seen = 1;
        end
        @(posedge clk); #2 req_valid = 1'b0;
        @(negedge clk);
        chk("ar_pre_wr_en", wr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rd_en", rd_en, 0); chk("ar_wr_en", wr_en, 0); chk("ar_strobe", wr_strobe, 0);
        chk("ar_resp_valid", resp_valid, 0); chk("ar_addr", addr, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); chk("ar_req_ready", req_ready, 1);
        rd_fixed = 32'h0F0E_0D0C;
        run_txn(0, 32'h0000_1008, 2'd2, 0, 0, bk, rk, ba, bw, bs, rdv, re);
        chk("ar_fresh_rdata", rdv, 32'h0F0E_0D0C); chk("ar_fresh_resp_cycle", rk, 2);

        // randomized traffic, checked every cycle by the model
        rd_fixed_en = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            req_valid    = ($urandom % 10) < 6;
            req_we       = 1'($urandom);
            req_addr     = $urandom;
            req_size     = 2'($urandom);
            req_unsigned = 1'($urandom);
            req_wdata    = $urandom;
            resp_ready   = ($urandom % 10) < 7;
        end
        @(posedge clk); #2 req_valid = 1'b0; resp_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dbus_master.md
Name: dbus_master

Overview:
- Core-side load/store initiator for the data bus (DBus).
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Drives the DBus responder signals: rd_en, wr_en, word addr, wr_data, wr_strobe. Captures rd_data, then aligns and sign/zero-extends it.
- Returns the result over a valid/ready response handshake, and flags misaligned or illegal-size accesses without touching the bus.

Parameters:
- ADDR_WIDTH, 32, byte-address width of req_addr; bus word address is ADDR_WIDTH-2 bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  master can accept a request (high only in IDLE)
- req_we  input  1  1=store, 0=load
- req_addr  input  ADDR_WIDTH  byte address
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  response available
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  aligned, extended load data; 0 for stores and errors
- resp_err  output  1  misaligned or illegal-size request; no bus access made
- rd_en  output  1  DBus read enable
- wr_en  output  1  DBus write enable
- addr  output  ADDR_WIDTH-2  DBus word address = req_addr[ADDR_WIDTH-1:2]
- wr_data  output  32  DBus write data, lane-replicated
- wr_strobe  output  4  DBus byte enables
- rd_data  input  32  DBus read data; valid combinationally in the cycle rd_en is high

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - rd_en=0, wr_en=0, addr=0, wr_data=0, wr_strobe=0.
  - req_ready=1 after reset deassertion.
  - Reset mid-transaction discards the request and any captured data; no partial bus strobe survives.
- FSM states IDLE, BUS, RESP:
  - IDLE: req_ready=1. On req_valid, latch all req_* fields.
    - If aligned and legal, go to BUS.
    - Else set resp_err=1, resp_rdata=0, go to RESP.
  - BUS: exactly one cycle. Drive registered bus outputs.
    - Load: rd_en=1, wr_en=0, wr_strobe=0; capture rd_data at the end of the cycle.
    - Store: wr_en=1, rd_en=0.
    - Always go to RESP.
  - RESP: resp_valid=1, outputs held stable. On resp_ready go to IDLE. No new request is accepted in RESP, even if resp_ready is high in the same cycle.
- Bus outputs are 0 in every state except BUS.
- Latency, with handshake in cycle N:
  - Legal access: bus strobe in N+1, resp_valid from N+2.
  - Error: no bus cycle, resp_valid from N+1.
  - Back-to-back throughput: one access per 3 cycles with resp_ready held high.
- Alignment, with off=req_addr[1:0]:
  - byte: always legal.
  - half: legal iff off[0]=0.
  - word: legal iff off=0.
  - size 11: always error.
- Store lane generation:
  - byte: wr_data={4{wdata[7:0]}}, wr_strobe=4'b0001<<off.
  - half: wr_data={2{wdata[15:0]}}, wr_strobe=4'b0011<<off.
  - word: wr_data=wdata, wr_strobe=4'b1111.
- Load extraction:
  - Shift: shifted = captured rd_data >> (8*off).
  - byte: low 8 bits, extended to 32 per req_unsigned.
  - half: low 16 bits, extended to 32 per req_unsigned.
  - word: unchanged, req_unsigned ignored.
- Store response: resp_rdata=0, resp_err=0.
- resp_err and resp_rdata are valid only while resp_valid=1. They remain driven with the last response value until the next response is loaded.

Test Plan:
- Word load addr 0x0000_1008, bus rd_data=0xDEADBEEF in the rd_en cycle -> addr=0x402, rd_en one cycle at N+1, resp_valid at N+2, resp_rdata=0xDEADBEEF, resp_err=0.
- Byte load addr 0x...03, rd_data=0x80FF_0000: signed -> resp_rdata=0xFFFFFF80; unsigned -> 0x00000080. Half load off=2 signed, same data -> 0xFFFF80FF.
- Byte store addr 0x...01, wdata=0x1234_56AB -> wr_en=1, wr_strobe=0010, wr_data=0xABABABAB. Half store off=2, wdata=0x0000_BEEF -> strobe 1100, wr_data=0xBEEFBEEF. Word store -> strobe 1111.
- Misaligned word load addr 0x...02, half store addr 0x...03, size=11 request -> no rd_en/wr_en pulse ever, resp_valid at N+1, resp_err=1, resp_rdata=0.
- Backpressure: resp_ready held 0 for 5 cycles -> resp_valid, resp_rdata, resp_err stable; req_ready=0; a concurrent req_valid is not accepted until one cycle after resp_ready=1.
- Async reset asserted mid-BUS, between clock edges -> rd_en/wr_en/wr_strobe drop to 0 immediately, resp_valid=0; after release req_ready=1 and a fresh word load completes correctly.
